// File: rtl/radix4_butterfly_pkg.sv
// Shared constants and helpers for the radix-4 butterfly stage.
package radix4_butterfly_pkg;

  localparam int DEF_NB    = 32;  // lane width: {re[W], im[W]}, W = NB/2
  localparam int DEF_FRAME = 8;   // beats per frame
  localparam int STAGES    = 3;   // sum/diff, combine, round/saturate

  // Beat-index counter width; a one-beat frame still gets a 1-bit counter.
  function automatic int cnt_width(input int frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction

endpackage

// File: rtl/radix4_butterfly_if.sv
// Beat bus between the commutator, the butterfly and the twiddle stage.
interface radix4_butterfly_if
  import radix4_butterfly_pkg::*;
#(
  parameter int NB = DEF_NB
);
  logic              start;
  logic              in_valid;
  logic [4*NB-1:0]   input_data;
  logic [4*NB-1:0]   output_data;
  logic              out_valid;
  logic              out_last;
  logic              ovf;

  modport master (
    output start, in_valid, input_data,
    input  output_data, out_valid, out_last, ovf
  );

  modport slave (
    input  start, in_valid, input_data,
    output output_data, out_valid, out_last, ovf
  );
endinterface

// File: rtl/radix4_butterfly_cplx_round_sat.sv
// One real component: optional /4 with round-half-up, then clamp to W bits.
module cplx_round_sat #(
  parameter int W     = 16,
  parameter int SCALE = 1
) (
  input  logic signed [W+1:0] v,
  output logic signed [W-1:0] q,
  output logic                sat
);
  localparam logic signed [W+2:0] TWO  = 2;
  localparam logic signed [W+2:0] MAXV = (W+3)'((2 ** (W-1)) - 1);
  localparam logic signed [W+2:0] MINV = -(W+3)'(2 ** (W-1));

  logic signed [W+2:0] vx;
  logic signed [W+2:0] sc;

  // One guard bit above the input keeps v+2 from wrapping before the shift.
  always_comb begin
    vx  = {v[W+1], v};
    sc  = (SCALE != 0) ? ((vx + TWO) >>> 2) : vx;
    sat = 1'b0;
    q   = sc[W-1:0];
    if (sc > MAXV) begin
      q   = MAXV[W-1:0];
      sat = 1'b1;
    end else if (sc < MINV) begin
      q   = MINV[W-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/radix4_butterfly.sv
// Radix-4 butterfly: 4-point DFT per beat (only +/-j rotations), optional /4
// scaling with saturation, frame-last tagging, sticky overflow.
module radix4_butterfly
  import radix4_butterfly_pkg::*;
#(
  parameter int NB    = DEF_NB,
  parameter int FRAME = DEF_FRAME,
  parameter int SCALE = 1
) (
  input logic               clk,
  input logic               reset,
  radix4_butterfly_if.slave bus
);
  localparam int W  = NB / 2;
  localparam int W1 = W + 1;
  localparam int W2 = W + 2;
  localparam int CW = cnt_width(FRAME);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  // ---------------- beat index ----------------
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic          last_in;

  // start forces the current beat to index 0, overriding any pending wrap.
  always_comb begin
    idx     = bus.start ? '0 : cnt;
    last_in = (idx == LAST_IDX);
  end

  // Counter advances on accepted beats only; start alone parks it at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (bus.in_valid) cnt <= last_in ? '0 : idx + CW'(1);
    else if (bus.start)    cnt <= '0;
  end

  // ---------------- valid/last shift registers ----------------
  logic [STAGES-1:0] vld_pipe;
  logic [STAGES-1:0] last_pipe;

  // Tags ride alongside the data; bubbles shift through as zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-2:0], bus.in_valid};
      last_pipe <= {last_pipe[STAGES-2:0], bus.in_valid & last_in};
    end
  end

  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.out_last  = last_pipe[STAGES-1];

  // ---------------- stage 1: sums and differences ----------------
  logic signed [W-1:0] x_re [4];
  logic signed [W-1:0] x_im [4];

  // Lane k sits at [(k+1)*NB-1 : k*NB], real half on top.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      x_re[k] = bus.input_data[k*NB+W +: W];
      x_im[k] = bus.input_data[k*NB +: W];
    end
  end

  logic signed [W1-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;

  // a = x0+x2, b = x0-x2, c = x1+x3, d = x1-x3, one bit of growth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_re <= '0; a_im <= '0; b_re <= '0; b_im <= '0;
      c_re <= '0; c_im <= '0; d_re <= '0; d_im <= '0;
    end else begin
      a_re <= W1'(x_re[0]) + W1'(x_re[2]);
      a_im <= W1'(x_im[0]) + W1'(x_im[2]);
      b_re <= W1'(x_re[0]) - W1'(x_re[2]);
      b_im <= W1'(x_im[0]) - W1'(x_im[2]);
      c_re <= W1'(x_re[1]) + W1'(x_re[3]);
      c_im <= W1'(x_im[1]) + W1'(x_im[3]);
      d_re <= W1'(x_re[1]) - W1'(x_re[3]);
      d_im <= W1'(x_im[1]) - W1'(x_im[3]);
    end
  end

  // ---------------- stage 2: combine with +/-j ----------------
  logic signed [W2-1:0] y_re [4];
  logic signed [W2-1:0] y_im [4];

  // y1 = b - j*d and y3 = b + j*d are just swaps and sign flips of d.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        y_re[k] <= '0;
        y_im[k] <= '0;
      end
    end else begin
      y_re[0] <= W2'(a_re) + W2'(c_re);
      y_im[0] <= W2'(a_im) + W2'(c_im);
      y_re[2] <= W2'(a_re) - W2'(c_re);
      y_im[2] <= W2'(a_im) - W2'(c_im);
      y_re[1] <= W2'(b_re) + W2'(d_im);
      y_im[1] <= W2'(b_im) - W2'(d_re);
      y_re[3] <= W2'(b_re) - W2'(d_im);
      y_im[3] <= W2'(b_im) + W2'(d_re);
    end
  end

  // ---------------- stage 3: round / saturate ----------------
  logic signed [W-1:0] q_re [4];
  logic signed [W-1:0] q_im [4];
  logic [3:0]          sat_re;
  logic [3:0]          sat_im;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    cplx_round_sat #(.W(W), .SCALE(SCALE)) u_re (
      .v(y_re[k]), .q(q_re[k]), .sat(sat_re[k])
    );
    cplx_round_sat #(.W(W), .SCALE(SCALE)) u_im (
      .v(y_im[k]), .q(q_im[k]), .sat(sat_im[k])
    );
  end

  logic [4*NB-1:0] q_packed;
  logic            sat_beat;

  // Repack the clamped results into lane order; only valid beats may flag.
  always_comb begin
    q_packed = '0;
    for (int k = 0; k < 4; k++) q_packed[k*NB +: NB] = {q_re[k], q_im[k]};
    sat_beat = vld_pipe[STAGES-2] & (|{sat_re, sat_im});
  end

  // Output register; start clears ovf but a clamp landing this edge still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.output_data <= '0;
      bus.ovf         <= 1'b0;
    end else begin
      bus.output_data <= q_packed;
      bus.ovf         <= (bus.start ? 1'b0 : bus.ovf) | sat_beat;
    end
  end

endmodule
